// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param: multi-baud UART receiver with oversampled majority vote and an output FIFO.
// Define UART_RX_BREAK_DETECT_EN to add the brk output and drop break frames from the FIFO.
module uart_rx_param #(
    parameter int CLK_FREQ      = 50000000,
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     src_clk,
    input  logic                     rst_n,
    input  logic                     rx_in,
    input  logic [1:0]               baud_sel,
    input  logic [2:0]               data_bits,
    input  logic [1:0]               parity_mode,
    input  logic                     two_stop,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_perr,
    output logic                     rx_ferr,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     overrun,
    input  logic                     overrun_clr,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                     brk,
`endif
    output logic                     busy
);

    // state  | meaning
    // IDLE   | waiting for a synchronised falling edge
    // START  | sampling the start bit; a voted 1 is a glitch
    // DATA   | shifting data bits in, LSB first
    // PARITY | checking the received parity bit
    // STOP1  | first stop bit; commits here unless two stop bits
    // STOP2  | second stop bit, then commit
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    localparam int DIV_9600   = (CLK_FREQ + (9600 * OVERSAMPLE) / 2) / (9600 * OVERSAMPLE);
    localparam int DIV_57600  = (CLK_FREQ + (57600 * OVERSAMPLE) / 2) / (57600 * OVERSAMPLE);
    localparam int DIV_115200 = (CLK_FREQ + (115200 * OVERSAMPLE) / 2) / (115200 * OVERSAMPLE);
    localparam int DIV_230400 = (CLK_FREQ + (230400 * OVERSAMPLE) / 2) / (230400 * OVERSAMPLE);
    localparam int DIV_W      = $clog2(DIV_9600 + 1);
    localparam int SW         = $clog2(OVERSAMPLE);
    localparam int IW         = $clog2(MAX_DATA_BITS);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int EW         = MAX_DATA_BITS + 2;

    localparam logic [SW-1:0] SAMP_A   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_V   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);

    function automatic logic [DIV_W-1:0] div_minus1(input logic [1:0] sel);
        case (sel)
            2'b00:   return DIV_W'(DIV_9600 - 1);
            2'b01:   return DIV_W'(DIV_57600 - 1);
            2'b10:   return DIV_W'(DIV_115200 - 1);
            default: return DIV_W'(DIV_230400 - 1);
        endcase
    endfunction

    function automatic logic [IW-1:0] last_index(input logic [2:0] db);
        int n;
        n = int'(db) + 5;
        if (n > MAX_DATA_BITS) n = MAX_DATA_BITS;
        return IW'(n - 1);
    endfunction

    state_t                   state, state_n;
    logic                     rx_meta, rx_sync, rx_prev;
    logic                     fall, start_det, tick, vote_tick, end_tick, vote;
    logic [DIV_W-1:0]         div_cnt;
    logic [SW-1:0]            samp_cnt;
    logic                     s_a, s_b;
    logic [1:0]               baud_q;
    logic [IW-1:0]            last_idx, bit_idx;
    logic                     par_en, par_odd, two_q;
    logic [MAX_DATA_BITS-1:0] data_sh;
    logic                     par_acc, perr_q, ferr_q;
    logic                     commit, commit_ferr;

    logic [EW-1:0]            mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr, rd_ptr;
    logic                     fifo_empty, fifo_full, push, pop, drop;
    logic [EW-1:0]            head;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign tick      = (state != S_IDLE) && (div_cnt == '0);
    assign vote_tick = tick && (samp_cnt == SAMP_V);
    assign end_tick  = tick && (samp_cnt == SAMP_END);
    assign vote      = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);

`ifdef UART_RX_BREAK_DETECT_EN
    logic wait_high, par_bit_q, break_cond, brk_hit;

    // After a break the line must go high again before a new start edge counts.
    assign start_det  = (state == S_IDLE) && fall && !wait_high;
    assign break_cond = (data_sh == '0) && !vote && (!par_en || !par_bit_q);

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_high <= 1'b0;
            par_bit_q <= 1'b0;
            brk       <= 1'b0;
        end else begin
            brk <= brk_hit;
            if (brk_hit)
                wait_high <= 1'b1;
            else if (rx_sync)
                wait_high <= 1'b0;
            if (start_det)
                par_bit_q <= 1'b0;
            else if (vote_tick && state == S_PARITY)
                par_bit_q <= vote;
        end
    end
`else
    assign start_det = (state == S_IDLE) && fall;
`endif

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n     = state;
        commit      = 1'b0;
        commit_ferr = ferr_q;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_hit     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start_det) state_n = S_START;
            end
            S_START: begin
                if (vote_tick && vote)
                    state_n = S_IDLE;
                else if (end_tick)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (end_tick && bit_idx == last_idx)
                    state_n = par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (end_tick) state_n = S_STOP1;
            end
            S_STOP1: begin
                if (vote_tick) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (break_cond) begin
                        brk_hit = 1'b1;
                        state_n = S_IDLE;
                    end else
`endif
                    if (!two_q) begin
                        commit      = 1'b1;
                        commit_ferr = !vote;
                        state_n     = S_IDLE;
                    end
                end else if (end_tick) begin
                    state_n = S_STOP2;
                end
            end
            S_STOP2: begin
                if (vote_tick) begin
                    commit      = 1'b1;
                    commit_ferr = ferr_q | !vote;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Frame configuration is frozen at the start edge so mid-frame changes cannot corrupt it.
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q   <= 2'b00;
            last_idx <= '0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            two_q    <= 1'b0;
            div_cnt  <= '0;
            samp_cnt <= '0;
            s_a      <= 1'b1;
            s_b      <= 1'b1;
            bit_idx  <= '0;
            data_sh  <= '0;
            par_acc  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else if (start_det) begin
            baud_q   <= baud_sel;
            last_idx <= last_index(data_bits);
            par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_odd  <= (parity_mode == 2'b10);
            two_q    <= two_stop;
            div_cnt  <= div_minus1(baud_sel);
            samp_cnt <= '0;
            bit_idx  <= '0;
            data_sh  <= '0;
            par_acc  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else if (state != S_IDLE) begin
            if (div_cnt == '0)
                div_cnt <= div_minus1(baud_q);
            else
                div_cnt <= div_cnt - 1'b1;
            if (tick)
                samp_cnt <= (samp_cnt == SAMP_END) ? '0 : samp_cnt + 1'b1;
            if (tick && samp_cnt == SAMP_A)
                s_a <= rx_sync;
            if (tick && samp_cnt == SAMP_B)
                s_b <= rx_sync;
            if (vote_tick) begin
                case (state)
                    S_DATA: begin
                        data_sh[bit_idx] <= vote;
                        par_acc          <= par_acc ^ vote;
                    end
                    S_PARITY: perr_q <= (vote != (par_acc ^ par_odd));
                    S_STOP1:  ferr_q <= !vote;
                    default: ;
                endcase
            end
            if (end_tick && state == S_DATA && bit_idx != last_idx)
                bit_idx <= bit_idx + 1'b1;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && rx_ready;
    assign push       = commit && (!fifo_full || pop);
    assign drop       = commit && fifo_full && !pop;

    always_ff @(posedge src_clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {perr_q, commit_ferr, data_sh};
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign rx_valid = !fifo_empty;
    assign rx_data  = fifo_empty ? '0 : head[MAX_DATA_BITS-1:0];
    assign rx_ferr  = fifo_empty ? 1'b0 : head[MAX_DATA_BITS];
    assign rx_perr  = fifo_empty ? 1'b0 : head[MAX_DATA_BITS+1];
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_param at a reduced 10 MHz clock (divisors 65/11/5/3).
module tb_uart_rx_param;

    localparam int CLK_FREQ   = 10000000;
    localparam int BIT_9600   = 65 * 16;
    localparam int BIT_57600  = 11 * 16;
    localparam int BIT_115200 = 5 * 16;
    localparam int BIT_230400 = 3 * 16;

    logic       src_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] baud_sel = 2'b00;
    logic [2:0] data_bits = 3'd3;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic [8:0] rx_data;
    logic       rx_perr, rx_ferr, rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun;
    logic       overrun_clr = 1'b0;
    logic       busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk;
`endif

    int n_checks = 0;
    int n_pass = 0;

    always #5 src_clk = ~src_clk;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16), .MAX_DATA_BITS(9), .FIFO_DEPTH(4)
    ) dut (
        .src_clk(src_clk), .rst_n(rst_n), .rx_in(rx_in), .baud_sel(baud_sel),
        .data_bits(data_bits), .parity_mode(parity_mode), .two_stop(two_stop),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .overrun(overrun), .overrun_clr(overrun_clr),
`ifdef UART_RX_BREAK_DETECT_EN
        .brk(brk),
`endif
        .busy(busy)
    );

    task automatic set_cfg(input logic [1:0] b, input logic [2:0] db, input logic [1:0] pm,
                           input logic ts);
        baud_sel = b; data_bits = db; parity_mode = pm; two_stop = ts;
    endtask

    // par: 0 none, 1 even, 2 odd
    task automatic send_frame(input int bit_cyc, input int nbits, input logic [8:0] data,
                              input int par, input logic flip_par, input int nstop,
                              input logic stop2_val);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ data[i];
        if (par == 2) p = ~p;
        p = p ^ flip_par;
        @(negedge src_clk);
        rx_in = 1'b0;
        repeat (bit_cyc) @(negedge src_clk);
        for (int i = 0; i < nbits; i++) begin
            rx_in = data[i];
            repeat (bit_cyc) @(negedge src_clk);
        end
        if (par != 0) begin
            rx_in = p;
            repeat (bit_cyc) @(negedge src_clk);
        end
        rx_in = 1'b1;
        repeat (bit_cyc - 1) @(negedge src_clk);
        if (nstop == 2) begin
            @(negedge src_clk);
            rx_in = stop2_val;
            repeat (bit_cyc - 1) @(negedge src_clk);
        end
        rx_in = 1'b1;
    endtask

    task automatic pop_one;
        @(negedge src_clk);
        rx_ready = 1'b1;
        @(negedge src_clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge src_clk);
        n_checks++;
        if (rx_data !== 9'h000 || rx_perr !== 1'b0 || rx_ferr !== 1'b0 || rx_valid !== 1'b0 ||
            overrun !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_values: data=%h perr=%b ferr=%b valid=%b ovr=%b busy=%b, want 000/0/0/0/0/0",
                     rx_data, rx_perr, rx_ferr, rx_valid, overrun, busy);
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge src_clk);
    endtask

    task automatic test_9600_8n1;
        set_cfg(2'b00, 3'd3, 2'b00, 1'b0);
        send_frame(BIT_9600, 8, 9'h052, 0, 1'b0, 1, 1'b1);
        @(negedge src_clk);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h052)
            $display("FAIL b9600_first_commit: valid=%b data=%h, want 1/052", rx_valid, rx_data);
        else n_pass++;
        repeat (20000) @(negedge src_clk);
        send_frame(BIT_9600, 8, 9'h052, 0, 1'b0, 1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge src_clk);
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== 9'h052 || rx_perr !== 1'b0 || rx_ferr !== 1'b0)
                $display("FAIL b9600_entry%0d: valid=%b data=%h perr=%b ferr=%b, want 1/052/0/0",
                         k, rx_valid, rx_data, rx_perr, rx_ferr);
            else n_pass++;
            pop_one();
        end
        n_checks++;
        if (rx_valid !== 1'b0)
            $display("FAIL b9600_drained: valid=%b, want 0", rx_valid);
        else n_pass++;
    endtask

    task automatic test_parity;
        set_cfg(2'b10, 3'd3, 2'b01, 1'b0);
        send_frame(BIT_115200, 8, 9'h0A5, 1, 1'b0, 1, 1'b1);
        repeat (BIT_115200) @(negedge src_clk);
        send_frame(BIT_115200, 8, 9'h0A5, 1, 1'b1, 1, 1'b1);
        repeat (BIT_115200) @(negedge src_clk);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h0A5 || rx_perr !== 1'b0 || rx_ferr !== 1'b0)
            $display("FAIL parity_good: valid=%b data=%h perr=%b ferr=%b, want 1/0a5/0/0",
                     rx_valid, rx_data, rx_perr, rx_ferr);
        else n_pass++;
        pop_one();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h0A5 || rx_perr !== 1'b1 || rx_ferr !== 1'b0)
            $display("FAIL parity_bad: valid=%b data=%h perr=%b ferr=%b, want 1/0a5/1/0",
                     rx_valid, rx_data, rx_perr, rx_ferr);
        else n_pass++;
        pop_one();
    endtask

    task automatic test_7o2;
        set_cfg(2'b01, 3'd2, 2'b10, 1'b1);
        send_frame(BIT_57600, 7, 9'h05A, 2, 1'b0, 2, 1'b0);
        repeat (BIT_57600) @(negedge src_clk);
        send_frame(BIT_57600, 7, 9'h05A, 2, 1'b0, 2, 1'b1);
        repeat (BIT_57600) @(negedge src_clk);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h05A || rx_perr !== 1'b0 || rx_ferr !== 1'b1)
            $display("FAIL stop2_low: valid=%b data=%h perr=%b ferr=%b, want 1/05a/0/1",
                     rx_valid, rx_data, rx_perr, rx_ferr);
        else n_pass++;
        pop_one();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h05A || rx_perr !== 1'b0 || rx_ferr !== 1'b0)
            $display("FAIL stop2_high: valid=%b data=%h perr=%b ferr=%b, want 1/05a/0/0",
                     rx_valid, rx_data, rx_perr, rx_ferr);
        else n_pass++;
        pop_one();
    endtask

    task automatic test_back_to_back;
        set_cfg(2'b11, 3'd3, 2'b00, 1'b0);
        for (int k = 1; k <= 5; k++)
            send_frame(BIT_230400, 8, 9'(k), 0, 1'b0, 1, 1'b1);
        repeat (BIT_230400) @(negedge src_clk);
        n_checks++;
        if (overrun !== 1'b1)
            $display("FAIL overrun_set: overrun=%b, want 1", overrun);
        else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge src_clk);
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== 9'(k) || rx_ferr !== 1'b0)
                $display("FAIL fifo_entry%0d: valid=%b data=%h ferr=%b, want 1/%h/0",
                         k, rx_valid, rx_data, rx_ferr, 9'(k));
            else n_pass++;
            pop_one();
        end
        n_checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b1)
            $display("FAIL fifo_drained: valid=%b overrun=%b, want 0/1", rx_valid, overrun);
        else n_pass++;
        @(negedge src_clk);
        overrun_clr = 1'b1;
        @(negedge src_clk);
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0)
            $display("FAIL overrun_clr: overrun=%b, want 0", overrun);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int waited;
        set_cfg(2'b11, 3'd3, 2'b00, 1'b0);
        @(negedge src_clk);
        rx_in = 1'b0;
        repeat (3) @(negedge src_clk);
        rx_in = 1'b1;
        waited = 0;
        while (busy !== 1'b1 && waited < 20) begin
            @(negedge src_clk);
            waited++;
        end
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL glitch_start_seen: busy=%b after %0d cycles, want 1", busy, waited);
        else n_pass++;
        repeat (200) @(negedge src_clk);
        n_checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0)
            $display("FAIL glitch_rejected: busy=%b valid=%b, want 0/0", busy, rx_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        set_cfg(2'b10, 3'd3, 2'b00, 1'b0);
        send_frame(BIT_115200, 8, 9'h033, 0, 1'b0, 1, 1'b1);
        repeat (BIT_115200) @(negedge src_clk);
        @(negedge src_clk);
        rx_in = 1'b0;
        repeat (BIT_115200) @(negedge src_clk);
        rx_in = 1'b1;
        repeat (2 * BIT_115200 + 10) @(negedge src_clk);
        n_checks++;
        if (busy !== 1'b1 || rx_valid !== 1'b1)
            $display("FAIL pre_reset_state: busy=%b valid=%b, want 1/1", busy, rx_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rx_data !== 9'h000 || rx_perr !== 1'b0 || rx_ferr !== 1'b0 || rx_valid !== 1'b0 ||
            overrun !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid_data: data=%h perr=%b ferr=%b valid=%b ovr=%b busy=%b, want 000/0/0/0/0/0",
                     rx_data, rx_perr, rx_ferr, rx_valid, overrun, busy);
        else n_pass++;
        repeat (3) @(negedge src_clk);
        rst_n = 1'b1;
        repeat (12 * BIT_115200) @(negedge src_clk);
        n_checks++;
        if (rx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_no_entry: valid=%b busy=%b, want 0/0", rx_valid, busy);
        else n_pass++;
    endtask

    task automatic test_break;
        int brk_cnt;
        brk_cnt = 0;
        set_cfg(2'b10, 3'd3, 2'b00, 1'b0);
        @(negedge src_clk);
        rx_in = 1'b0;
        for (int i = 0; i < 12 * BIT_115200; i++) begin
            @(negedge src_clk);
`ifdef UART_RX_BREAK_DETECT_EN
            if (brk === 1'b1) brk_cnt++;
`endif
        end
        rx_in = 1'b1;
        for (int i = 0; i < 2 * BIT_115200; i++) begin
            @(negedge src_clk);
`ifdef UART_RX_BREAK_DETECT_EN
            if (brk === 1'b1) brk_cnt++;
`endif
        end
`ifdef UART_RX_BREAK_DETECT_EN
        n_checks++;
        if (brk_cnt !== 1 || rx_valid !== 1'b0)
            $display("FAIL break_pulse: brk_cycles=%0d valid=%b, want 1/0", brk_cnt, rx_valid);
        else n_pass++;
`else
        n_checks++;
        if (brk_cnt !== 0 || rx_valid !== 1'b1 || rx_data !== 9'h000 || rx_perr !== 1'b0 ||
            rx_ferr !== 1'b1)
            $display("FAIL break_as_data: valid=%b data=%h perr=%b ferr=%b, want 1/000/0/1",
                     rx_valid, rx_data, rx_perr, rx_ferr);
        else n_pass++;
        pop_one();
`endif
        send_frame(BIT_115200, 8, 9'h052, 0, 1'b0, 1, 1'b1);
        repeat (BIT_115200) @(negedge src_clk);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h052 || rx_perr !== 1'b0 || rx_ferr !== 1'b0)
            $display("FAIL after_break: valid=%b data=%h perr=%b ferr=%b, want 1/052/0/0",
                     rx_valid, rx_data, rx_perr, rx_ferr);
        else n_pass++;
        pop_one();
    endtask

    initial begin
        test_reset();
        test_9600_8n1();
        test_parity();
        test_7o2();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        test_break();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, multi-baud UART receiver with a configurable frame format and an output FIFO with a valid/ready handshake.
- Next generation of the fixed 8N1 receive path inside UART_BCD. Adds runtime-selectable data bits, parity and stop bits, 16x oversampling with majority vote, glitch rejection and error reporting.
- Sits between the DataIn pin and the display/TX logic.

Parameters:
- CLK_FREQ, 50000000, src_clk frequency in Hz.
- OVERSAMPLE, 16, sample ticks per bit; even, minimum 8.
- MAX_DATA_BITS, 9, width of rx_data; supported data bits 5..MAX_DATA_BITS.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- src_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_in  in  1  serial line; idles high; asynchronous to src_clk.
- baud_sel  in  2  00=9600, 01=57600, 10=115200, 11=230400.
- data_bits  in  3  number of data bits minus 5 (0..4); values above MAX_DATA_BITS-5 saturate to MAX_DATA_BITS.
- parity_mode  in  2  00=none, 01=even, 10=odd, 11=none.
- two_stop  in  1  1 = two stop bits expected.
- rx_data  out  MAX_DATA_BITS  head-of-FIFO data, LSB-aligned, unused MSBs zero.
- rx_perr  out  1  parity error flag of the head entry.
- rx_ferr  out  1  framing error flag of the head entry.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head entry.
- overrun  out  1  sticky; a frame was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun.
- busy  out  1  a frame is in progress (any state except IDLE).

Behaviour:
- Reset: rx_data=0, rx_perr=0, rx_ferr=0, rx_valid=0, overrun=0, busy=0. FIFO is emptied, FSM goes to IDLE, synchroniser flops preset to 1. Reset mid-frame abandons the frame silently.
- rx_in passes through a 2-flop synchroniser; 2-cycle latency to the FSM.
- Tick generator: divisor = round(CLK_FREQ/(baud*OVERSAMPLE)). Gives 326/54/27/14 at the defaults. The divisor counter restarts when a start edge is detected.
- baud_sel, data_bits, parity_mode and two_stop are latched on start detection. Changes mid-frame have no effect until the next frame.
- Bit value = majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on a synchronised falling edge.
  - START: if the voted start bit is 1, treat it as a glitch and return to IDLE with no FIFO write; otherwise go to DATA.
  - DATA shifts LSB first, counting latched data_bits. It then goes to PARITY if parity is enabled, else STOP1.
  - PARITY: perr = received parity bit differs from the computed even/odd parity.
  - STOP1: ferr = voted stop bit is 0. Go to STOP2 if two_stop, else commit.
  - STOP2: ferr |= voted bit is 0, then commit.
- Commit: the FSM returns to IDLE at mid-stop-bit, so back-to-back frames are accepted.
- Commit behaviour with FIFO state:
  - FIFO not full: the entry is written. rx_valid rises on the cycle after commit.
  - FIFO full with rx_ready=1 on the commit cycle: pop and write both occur; the entry is not dropped.
  - FIFO full otherwise: the entry is dropped and overrun is set.
- Overrun set and overrun_clr on the same cycle: set wins.
- Pop: rx_valid && rx_ready. The head advances the next cycle. FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.

Optional Feature:
- Macro UART_RX_BREAK_DETECT_EN.
- When defined, this adds output port brk (1 bit, reset 0). brk pulses for 1 cycle when a frame has all data bits 0, parity bit 0 if enabled, and STOP1 voted 0.
- A break frame is not written to the FIFO. The FSM waits in IDLE for rx_in to return high before accepting a new start edge.
- When not defined, there is no brk port, and a break is stored as data 0 with ferr=1.

Test Plan:
- 9600, 8N1, 0x52 sent twice with ~20000 idle cycles between frames -> two FIFO entries of 0x052 with perr=0 and ferr=0; rx_valid high after the first commit; rx_ready=1 pops both.
- 115200, 8E1, 0xA5 with a correct parity bit (0) then a flipped one (1) -> entries 0x0A5/perr=0 then 0x0A5/perr=1.
- 57600, 7O2, 0x5A with the second stop bit forced to 0 -> entry 0x05A with ferr=1; same frame with both stop bits 1 -> ferr=0.
- rx_ready=0, 5 frames 0x01..0x05 at 230400, FIFO_DEPTH=4 -> entries 0x01..0x04 retained, overrun=1. Pulse overrun_clr -> overrun=0.
- 3-tick low glitch on idle rx_in -> no FIFO write, busy returns to 0; rst_n asserted mid-DATA -> all outputs at reset values immediately, no entry written.
- With UART_RX_BREAK_DETECT_EN, 8N1 all-zero line held for 12 bit times -> single-cycle brk pulse, FIFO stays empty, next 0x52 frame received correctly.
